rv32_exec_stage: RTL and testbench
==================================

# rv32_exec_stage

Execute stage of the RV32 integer pipeline, between decode and memory. It accepts one decoded instruction per cycle over a valid/ready handshake and evaluates it on a single `rv32_int_alu` instance. It registers the result towards the memory stage, resolves conditional branches and jumps from the ALU compare flags, and emits a one-cycle redirect to fetch. Instructions tagged with a stale epoch are squashed after a redirect.

## Interface
Parameters:
- None. All widths are fixed by `rv32_word` (32 bit).

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dec_valid` in 1: decode presents an instruction.
- `dec_ready` out 1: the stage can accept; `dec_ready = !mem_valid || mem_ready`.
- `dec_instr` in `rv32_exec_instr`: fields are
  - `pc`, `op1`, `op2` (`rv32_word`)
  - `alu_op` (`alu_opsel_t`)
  - `br_kind` (`br_kind_t`)
  - `br_target` (`rv32_word`)
  - `rd` (5 bit), `wb_en` (1 bit), `epoch` (1 bit)
- `mem_valid` out 1: `mem_out` holds a live result.
- `mem_ready` in 1: memory stage consumes `mem_out` when `mem_valid && mem_ready`.
- `mem_out` out `rv32_exec_result`: fields are `pc`, `result` (`rv32_word`), `rd`, `wb_en`.
- `redirect_valid` out 1: one-cycle pulse; fetch must restart at `redirect_pc`.
- `redirect_pc` out 32: target of the taken branch or jump.

## Operation
- **Accept.** Acceptance occurs on a rising edge with `dec_valid && dec_ready`. The ALU is driven combinationally from `dec_instr` (`op1`, `op2`, `alu_op`).
- **Live instruction.** An instruction is live when `dec_instr.epoch == cur_epoch`. On acceptance:
  - `mem_out` is loaded with `{pc, alu result, rd, wb_en}`.
  - `mem_valid` is set to 1.
- **Stale instruction.** Any instruction with a mismatched epoch is accepted and dropped:
  - no `mem_out` write;
  - no redirect;
  - `mem_valid` is cleared if the old entry drains in the same cycle.
- **Branch evaluation** (decode supplies `alu_op` SUB for signed branches and SUBU for unsigned branches):
  - BR_NONE: never taken.
  - BR_EQ: taken on flags == CMP_Z.
  - BR_NE: taken on flags != CMP_Z.
  - BR_LT and BR_LTU: taken on flags == CMP_N.
  - BR_GE and BR_GEU: taken on flags != CMP_N.
  - BR_JUMP: always taken. Decode drives `op1 = pc`, `op2 = 4`, ADD, so the result is the link address.
- **Taken live instruction.** On the accept edge:
  - `redirect_valid <= 1`;
  - `redirect_pc <= br_target`;
  - `cur_epoch` toggles.
- **Redirect pulse.** `redirect_valid` deasserts on the following edge unless another live taken instruction is accepted. That is impossible back-to-back, because the toggled epoch makes the next instruction stale until fetch retags.
- **Drain.** `mem_valid` clears on an edge with `mem_ready` and no new live acceptance.
- **Accept and drain together.** Acceptance in the same cycle as a drain keeps `mem_valid = 1` and replaces `mem_out`.
- **Holding.** While `mem_valid && !mem_ready`, the following are held stable and nothing is accepted:
  - `mem_out`, `mem_valid`;
  - `dec_ready = 0`.

## Timing
- Latency is 1 cycle from the acceptance edge to `mem_valid` and `redirect_valid`. Throughput is 1 instruction per cycle when `mem_ready` is held high.
- Reset values: `mem_valid = 0`, `mem_out = 0`, `redirect_valid = 0`, `redirect_pc = 0`, `cur_epoch = 0`.
- `dec_ready` is combinational from `mem_valid` and `mem_ready`. There is no combinational path from `dec_instr` to any output.
- Reset asserted mid-operation discards the buffered result and any pending redirect on that edge. `dec_ready` reads 1 in the cycle after reset.
- A redirect is never produced by an instruction that is not accepted, i.e. while stalled.

## Structure
- Shared package `rv32_exec_pkg`: `br_kind_t` enum (BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP), `rv32_exec_instr`, `rv32_exec_result`. It imports `rv32_word`, `alu_opsel_t` and `cmp_flags_t` from the existing type and ALU definitions.
- Sub-modules:
  - `rv32_int_alu`, instantiated once.
  - `rv32_branch_eval`, a combinational unit mapping (`br_kind`, `cmp_flags_t`) to `taken`.
- The top contains the output register, epoch flop and redirect register.

## Test plan
- **ADD.** Stimulus: `op1 = 5`, `op2 = 7`, `alu_op` ADD, `rd = 3`, `wb_en = 1`, `mem_ready = 1`. Required: next cycle `mem_valid = 1`, `result = 12`, `rd = 3`. No redirect.
- **Taken BLT.** Stimulus: `op1 = 0xFFFFFFFF`, `op2 = 1`, SUB, `br_target = 0x100`. Required: `redirect_valid` pulses one cycle with `redirect_pc = 0x100`; `cur_epoch` becomes 1. The following instruction with epoch 0 yields no `mem_valid`.
- **Not-taken BLTU.** Same operands with SUBU. Required: no redirect; epoch unchanged.
- **Backpressure.** Hold `mem_ready = 0` for 3 cycles with `dec_valid = 1`. Required: `dec_ready = 0`, `mem_out` stable. On release the pending instruction is accepted and `mem_valid` stays 1 continuously.
- **Jump.** Stimulus: `pc = 0x40`, `op1 = 0x40`, `op2 = 4`, BR_JUMP, `br_target = 0x80`. Required: `result = 0x44`, `redirect_pc = 0x80`.
- **Reset mid-stall.** Assert `rst` while `mem_valid = 1`, `mem_ready = 0`. Required: next cycle `mem_valid = 0`, `redirect_valid = 0`, `dec_ready = 1`, epoch 0.

Source files
------------

// File: rtl/rv32_alu_pkg.sv
// ----------------------------------------------------------------------
// rv32_alu_pkg: base word type, ALU operation select and compare flags.
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

package rv32_alu_pkg;

   typedef logic [31:0] rv32_word;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SUBU = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10,
      ALU_PASB = 4'd11
   } alu_opsel_t;

   // Three-way outcome of op1 versus op2: zero (equal), negative (less), positive (greater).
   typedef enum logic [1:0] {
      CMP_Z = 2'd0,
      CMP_N = 2'd1,
      CMP_P = 2'd2
   } cmp_flags_t;

endpackage

`default_nettype wire

// File: rtl/rv32_exec_pkg.sv
// ----------------------------------------------------------------------
// rv32_exec_pkg: branch kinds and execute-stage instruction/result records.
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

package rv32_exec_pkg;
   import rv32_alu_pkg::*;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_EQ   = 3'd1,
      BR_NE   = 3'd2,
      BR_LT   = 3'd3,
      BR_GE   = 3'd4,
      BR_LTU  = 3'd5,
      BR_GEU  = 3'd6,
      BR_JUMP = 3'd7
   } br_kind_t;

   typedef struct packed {
      rv32_word   pc;
      rv32_word   op1;
      rv32_word   op2;
      alu_opsel_t alu_op;
      br_kind_t   br_kind;
      rv32_word   br_target;
      logic [4:0] rd;
      logic       wb_en;
      logic       epoch;
   } rv32_exec_instr;

   typedef struct packed {
      rv32_word   pc;
      rv32_word   result;
      logic [4:0] rd;
      logic       wb_en;
   } rv32_exec_result;

endpackage

`default_nettype wire

// File: rtl/rv32_branch_eval.sv
// ----------------------------------------------------------------------
// rv32_branch_eval: maps branch kind and ALU compare flags to a taken decision.
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

module rv32_branch_eval
   import rv32_alu_pkg::*;
   import rv32_exec_pkg::*;
(
   input  br_kind_t   br_kind_i,
   input  cmp_flags_t flags_i,
   output logic       taken_o
);

   // Signedness of LT/GE is already folded into the flags by the ALU op.
   always_comb begin
      taken_o = 1'b0;
      case (br_kind_i)
         BR_NONE: taken_o = 1'b0;
         BR_EQ:   taken_o = (flags_i == CMP_Z);
         BR_NE:   taken_o = (flags_i != CMP_Z);
         BR_LT:   taken_o = (flags_i == CMP_N);
         BR_LTU:  taken_o = (flags_i == CMP_N);
         BR_GE:   taken_o = (flags_i != CMP_N);
         BR_GEU:  taken_o = (flags_i != CMP_N);
         BR_JUMP: taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rv32_int_alu.sv
// ----------------------------------------------------------------------
// rv32_int_alu: combinational RV32 integer ALU with three-way compare flags.
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

module rv32_int_alu
   import rv32_alu_pkg::*;
(
   input  rv32_word   a_i,
   input  rv32_word   b_i,
   input  alu_opsel_t op_i,
   output rv32_word   result_o,
   output cmp_flags_t flags_o
);

   logic w_lt_s;
   logic w_lt_u;
   logic w_lt;

   assign w_lt_s = ($signed(a_i) < $signed(b_i));
   assign w_lt_u = (a_i < b_i);
   // Only SUBU requests an unsigned ordering; every other op orders signed.
   assign w_lt   = (op_i == ALU_SUBU) ? w_lt_u : w_lt_s;

   always_comb begin
      if (a_i == b_i) begin
         flags_o = CMP_Z;
      end else if (w_lt) begin
         flags_o = CMP_N;
      end else begin
         flags_o = CMP_P;
      end
   end

   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_SUBU: result_o = a_i - b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SLL:  result_o = a_i << b_i[4:0];
         ALU_SRL:  result_o = a_i >> b_i[4:0];
         ALU_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
         ALU_SLT:  result_o = {31'd0, w_lt_s};
         ALU_SLTU: result_o = {31'd0, w_lt_u};
         ALU_PASB: result_o = b_i;
         default:  result_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rv32_exec_stage.sv
// ----------------------------------------------------------------------
// rv32_exec_stage: RV32 execute stage with result register, branch redirect and epoch squash.
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

module rv32_exec_stage
   import rv32_alu_pkg::*;
   import rv32_exec_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            dec_valid,
   output logic            dec_ready,
   input  rv32_exec_instr  dec_instr,
   output logic            mem_valid,
   input  logic            mem_ready,
   output rv32_exec_result mem_out,
   output logic            redirect_valid,
   output logic [31:0]     redirect_pc
);

   rv32_word        alu_result;
   cmp_flags_t      alu_flags;
   logic            br_taken;

   logic            accept;
   logic            live;
   logic            live_taken;

   logic            mem_valid_q,      mem_valid_d;
   rv32_exec_result mem_out_q,        mem_out_d;
   logic            redirect_valid_q, redirect_valid_d;
   rv32_word        redirect_pc_q,    redirect_pc_d;
   logic            cur_epoch_q,      cur_epoch_d;

   rv32_int_alu u_alu (
      .a_i      (dec_instr.op1),
      .b_i      (dec_instr.op2),
      .op_i     (dec_instr.alu_op),
      .result_o (alu_result),
      .flags_o  (alu_flags)
   );

   rv32_branch_eval u_branch_eval (
      .br_kind_i (dec_instr.br_kind),
      .flags_i   (alu_flags),
      .taken_o   (br_taken)
   );

   assign dec_ready  = !mem_valid_q || mem_ready;
   assign accept     = dec_valid && dec_ready;
   // Stale-epoch instructions are consumed but leave no architectural trace.
   assign live       = accept && (dec_instr.epoch == cur_epoch_q);
   assign live_taken = live && br_taken;

   always_comb begin
      mem_valid_d      = mem_valid_q;
      mem_out_d        = mem_out_q;
      redirect_valid_d = live_taken;
      redirect_pc_d    = redirect_pc_q;
      cur_epoch_d      = cur_epoch_q;

      if (live) begin
         mem_valid_d      = 1'b1;
         mem_out_d.pc     = dec_instr.pc;
         mem_out_d.result = alu_result;
         mem_out_d.rd     = dec_instr.rd;
         mem_out_d.wb_en  = dec_instr.wb_en;
      end else if (mem_ready) begin
         mem_valid_d = 1'b0;
      end

      if (live_taken) begin
         redirect_pc_d = dec_instr.br_target;
         cur_epoch_d   = !cur_epoch_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid_q      <= 1'b0;
         mem_out_q        <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         cur_epoch_q      <= 1'b0;
      end else begin
         mem_valid_q      <= mem_valid_d;
         mem_out_q        <= mem_out_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         cur_epoch_q      <= cur_epoch_d;
      end
   end

   assign mem_valid      = mem_valid_q;
   assign mem_out        = mem_out_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32_exec_stage.sv
// ----------------------------------------------------------------------
// tb_rv32_exec_stage: directed vectors for rv32_exec_stage, checked against a reference model.
// Revision: 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_rv32_exec_stage;
   import rv32_alu_pkg::*;
   import rv32_exec_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            dec_valid;
   logic            dec_ready;
   rv32_exec_instr  dec_instr;
   logic            mem_valid;
   logic            mem_ready;
   rv32_exec_result mem_out;
   logic            redirect_valid;
   logic [31:0]     redirect_pc;

   int checks   = 0;
   int failures = 0;
   logic cmp_en;

   always #5 clk = ~clk;

   rv32_exec_stage dut (
      .clk            (clk),
      .rst            (rst),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_out        (mem_out),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // Reference model: architectural meaning of each op and branch, written directly.
   function automatic rv32_word ref_alu(input alu_opsel_t op, input rv32_word a, input rv32_word b);
      case (op)
         ALU_ADD:            return a + b;
         ALU_SUB, ALU_SUBU:  return a - b;
         ALU_AND:            return a & b;
         ALU_OR:             return a | b;
         ALU_XOR:            return a ^ b;
         ALU_SLL:            return a << b[4:0];
         ALU_SRL:            return a >> b[4:0];
         ALU_SRA:            return $signed(a) >>> b[4:0];
         ALU_SLT:            return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU:           return (a < b) ? 32'd1 : 32'd0;
         ALU_PASB:           return b;
         default:            return 32'd0;
      endcase
   endfunction

   function automatic logic ref_taken(input rv32_exec_instr i);
      logic less;
      less = (i.alu_op == ALU_SUBU) ? (i.op1 < i.op2) : ($signed(i.op1) < $signed(i.op2));
      case (i.br_kind)
         BR_EQ:          return i.op1 == i.op2;
         BR_NE:          return i.op1 != i.op2;
         BR_LT, BR_LTU:  return less;
         BR_GE, BR_GEU:  return !less;
         BR_JUMP:        return 1'b1;
         default:        return 1'b0;
      endcase
   endfunction

   logic            m_valid;
   rv32_exec_result m_out;
   logic            m_rv;
   rv32_word        m_rpc;
   logic            m_ep;
   logic            t_acc;
   logic            t_live;
   logic            t_tk;

   assign t_acc  = dec_valid && (!m_valid || mem_ready);
   assign t_live = t_acc && (dec_instr.epoch == m_ep);
   assign t_tk   = t_live && ref_taken(dec_instr);

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_out   <= '0;
         m_rv    <= 1'b0;
         m_rpc   <= '0;
         m_ep    <= 1'b0;
      end else begin
         m_rv <= t_tk;
         if (t_tk) begin
            m_rpc <= dec_instr.br_target;
            m_ep  <= ~m_ep;
         end
         if (t_live) begin
            m_valid <= 1'b1;
            m_out   <= '{pc: dec_instr.pc,
                         result: ref_alu(dec_instr.alu_op, dec_instr.op1, dec_instr.op2),
                         rd: dec_instr.rd, wb_en: dec_instr.wb_en};
         end else if (mem_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic rv32_exec_instr mk(input rv32_word pc, input rv32_word a, input rv32_word b,
                                         input alu_opsel_t op, input br_kind_t bk, input rv32_word tgt,
                                         input logic [4:0] rd, input logic wb, input logic ep);
      rv32_exec_instr i;
      i.pc = pc; i.op1 = a; i.op2 = b; i.alu_op = op; i.br_kind = bk;
      i.br_target = tgt; i.rd = rd; i.wb_en = wb; i.epoch = ep;
      return i;
   endfunction

   alu_opsel_t v_op  [9] = '{ALU_XOR, ALU_SLL, ALU_SRA, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_SUB};
   rv32_word   v_a   [9] = '{32'hF0F0F0F0, 32'h00000001, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFF00FF00, 32'h00FF0000, 32'h00000003};
   rv32_word   v_b   [9] = '{32'h0FF00FF0, 32'd31, 32'd4, 32'd4, 32'd1, 32'd1,
                             32'h0F0F0F0F, 32'h0000FF00, 32'h00000005};
   rv32_word   v_exp [9] = '{32'hFF00FF00, 32'h80000000, 32'hF8000000, 32'h08000000, 32'd1, 32'd0,
                             32'h0F000F00, 32'h00FFFF00, 32'hFFFFFFFE};

   br_kind_t   b_kind [5] = '{BR_EQ, BR_NE, BR_GE, BR_GEU, BR_NE};
   alu_opsel_t b_op   [5] = '{ALU_SUB, ALU_SUB, ALU_SUB, ALU_SUBU, ALU_SUB};
   rv32_word   b_a    [5] = '{32'd3, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd1};
   rv32_word   b_b    [5] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd2};
   rv32_word   b_tgt  [5] = '{32'h300, 32'h310, 32'h320, 32'h400, 32'h500};
   logic       b_ep   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   logic       b_tk   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst       = 1'b1;
      dec_valid = 1'b0;
      mem_ready = 1'b1;
      dec_instr = '0;
      cmp_en    = 1'b0;

      fork
         forever begin
            @(negedge clk);
            if (cmp_en) begin
               check("dec_ready",      dec_ready,       !m_valid || mem_ready);
               check("mem_valid",      mem_valid,       m_valid);
               check("redirect_valid", redirect_valid,  m_rv);
               check("redirect_pc",    redirect_pc,     m_rpc);
               check("out_pc",         mem_out.pc,      m_out.pc);
               check("out_result",     mem_out.result,  m_out.result);
               check("out_rd",         mem_out.rd,      m_out.rd);
               check("out_wb_en",      mem_out.wb_en,   m_out.wb_en);
            end
         end
      join_none

      step();
      cmp_en = 1'b1;
      step();
      check("rst_mem_valid", mem_valid, 0);
      check("rst_redirect", redirect_valid, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_dec_ready", dec_ready, 1);
      check("rst_out_result", mem_out.result, 0);
      rst = 1'b0;

      dec_instr = mk(32'h10, 32'd5, 32'd7, ALU_ADD, BR_NONE, 32'h0, 5'd3, 1'b1, 1'b0);
      dec_valid = 1'b1;
      step();
      check("add_valid", mem_valid, 1);
      check("add_result", mem_out.result, 12);
      check("add_rd", mem_out.rd, 3);
      check("add_no_redirect", redirect_valid, 0);

      dec_instr = mk(32'h14, 32'hFFFFFFFF, 32'd1, ALU_SUB, BR_LT, 32'h100, 5'd0, 1'b0, 1'b0);
      step();
      check("blt_redirect", redirect_valid, 1);
      check("blt_redirect_pc", redirect_pc, 32'h100);
      check("blt_result", mem_out.result, 32'hFFFFFFFE);

      dec_instr = mk(32'h18, 32'd1, 32'd1, ALU_ADD, BR_NONE, 32'h0, 5'd5, 1'b1, 1'b0);
      step();
      check("stale_redirect_off", redirect_valid, 0);
      check("stale_no_valid", mem_valid, 0);
      check("stale_no_write", mem_out.pc, 32'h14);

      dec_instr = mk(32'h100, 32'hFFFFFFFF, 32'd1, ALU_SUBU, BR_LTU, 32'h200, 5'd0, 1'b0, 1'b1);
      step();
      check("bltu_no_redirect", redirect_valid, 0);
      check("bltu_valid", mem_valid, 1);
      check("bltu_redirect_pc_held", redirect_pc, 32'h100);

      dec_instr = mk(32'h104, 32'd2, 32'd3, ALU_ADD, BR_NONE, 32'h0, 5'd7, 1'b1, 1'b1);
      step();
      check("epoch_kept_valid", mem_valid, 1);
      check("epoch_kept_result", mem_out.result, 5);

      mem_ready = 1'b0;
      dec_instr = mk(32'h108, 32'd10, 32'd20, ALU_ADD, BR_NONE, 32'h0, 5'd8, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp_dec_ready", dec_ready, 0);
         check("bp_valid", mem_valid, 1);
         check("bp_hold_result", mem_out.result, 5);
      end
      mem_ready = 1'b1;
      step();
      check("bp_release_valid", mem_valid, 1);
      check("bp_release_result", mem_out.result, 30);
      check("bp_release_rd", mem_out.rd, 8);

      dec_instr = mk(32'h40, 32'h40, 32'd4, ALU_ADD, BR_JUMP, 32'h80, 5'd1, 1'b1, 1'b1);
      step();
      check("jal_result", mem_out.result, 32'h44);
      check("jal_redirect", redirect_valid, 1);
      check("jal_redirect_pc", redirect_pc, 32'h80);
      dec_valid = 1'b0;
      step();
      check("jal_pulse_end", redirect_valid, 0);
      check("drain_valid", mem_valid, 0);

      dec_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         dec_instr = mk(32'h200 + 32'(4 * k), v_a[k], v_b[k], v_op[k], BR_NONE, 32'h0, 5'd2, 1'b1, 1'b0);
         step();
         check("alu_vec", mem_out.result, v_exp[k]);
      end

      for (int k = 0; k < 5; k++) begin
         dec_instr = mk(32'h280 + 32'(4 * k), b_a[k], b_b[k], b_op[k], b_kind[k], b_tgt[k], 5'd0, 1'b0, b_ep[k]);
         step();
         check("br_taken", redirect_valid, b_tk[k]);
         if (b_tk[k]) check("br_target", redirect_pc, b_tgt[k]);
      end

      dec_instr = mk(32'h600, 32'd1, 32'd2, ALU_ADD, BR_NONE, 32'h0, 5'd9, 1'b1, 1'b1);
      step();
      check("pre_rst_valid", mem_valid, 1);
      mem_ready = 1'b0;
      dec_instr = mk(32'h604, 32'd1, 32'd1, ALU_SUB, BR_EQ, 32'h666, 5'd0, 1'b0, 1'b1);
      step();
      check("stall_no_redirect", redirect_valid, 0);
      check("stall_valid", mem_valid, 1);
      rst = 1'b1;
      step();
      check("rst_stall_valid", mem_valid, 0);
      check("rst_stall_redirect", redirect_valid, 0);
      check("rst_stall_dec_ready", dec_ready, 1);
      rst = 1'b0;
      mem_ready = 1'b1;
      dec_instr = mk(32'h700, 32'd4, 32'd4, ALU_ADD, BR_NONE, 32'h0, 5'd10, 1'b1, 1'b0);
      step();
      check("rst_epoch_zero", mem_valid, 1);
      check("rst_epoch_result", mem_out.result, 8);

      dec_valid = 1'b0;
      step();
      step();
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
